cruise_stalk_ctrl: RTL and testbench
====================================

// Module: cruise_stalk_ctrl
// PURPOSE
//  Driver-side front end for cruise_control: synchronises and debounces raw stalk
//  buttons and brake switch, then issues the one-clock command pulses
//  (set/accel/coast/cancel/resume/brake) that cruise_control consumes.
//  Sits between the steering-column switch pins and cruise_control's inputs.
//  Guarantees at most one command pulse per clock, with fixed priority.
// PARAMETERS
//  DEBOUNCE_CYCLES  20000  cycles an input must be stable before it is accepted (>=2)
//  REPEAT_DELAY     500000 cycles accel/coast held before auto-repeat starts
//  REPEAT_PERIOD    250000 cycles between auto-repeat pulses while still held
//  CNT_W            20     width of the debounce/repeat counters (must hold max of above)
// PORTS
//  clock       in   1  system clock, rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  btn_set     in   1  raw SET button, async, active-high
//  btn_accel   in   1  raw ACCEL button
//  btn_coast   in   1  raw COAST button
//  btn_cancel  in   1  raw CANCEL button
//  btn_resume  in   1  raw RESUME button
//  brake_sw    in   1  raw brake-pedal switch
//  set         out  1  one-clock command pulse to cruise_control (same for next five)
//  accel       out  1
//  coast       out  1
//  cancel      out  1
//  resume      out  1
//  brake       out  1  pulse on brake press only (not a level)
//  brake_held  out  1  debounced brake level
// BEHAVIOUR
//  - Reset: all outputs 0, synchronisers 0, every debouncer in IDLE, counters 0.
//    Reset may assert at any time; it clears in-flight debounce and repeat state.
//  - Each raw input: 2-flop synchroniser, then debouncer FSM:
//    IDLE -(s=1)-> CHK_PRESS(cnt=1); CHK_PRESS: s=0 -> IDLE, cnt==DEBOUNCE_CYCLES-1
//    -> PRESSED + press event, else cnt++; PRESSED -(s=0)-> CHK_REL(cnt=1);
//    CHK_REL: s=1 -> PRESSED (no new event), cnt==DEBOUNCE_CYCLES-1 -> IDLE, else cnt++.
//  - Latency: raw input high and stable from edge 0 -> pulse high for exactly one
//    clock, registered, after edge DEBOUNCE_CYCLES+2. Glitches shorter than
//    DEBOUNCE_CYCLES produce no pulse.
//  - Arbiter (registered output): priority brake > cancel > set > resume > accel > coast.
//    Same-cycle lower-priority events are dropped, never queued.
//  - accel and coast both debounced-pressed: neither pulses (incl. repeats) until one releases.
//  - While brake_held=1: set, resume, accel, coast events suppressed; cancel still passes.
//  - Counter saturates; no wrap-around under any hold duration.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: accel/coast held in PRESSED emit an extra pulse after
//    REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles until release; repeat timer
//    restarts from 0 on each new press; repeat pulses go through the arbiter.
//  AUTO_REPEAT_EN undefined: exactly one pulse per press; repeat counters and
//    REPEAT_* parameters unused (no logic generated).
// STRUCTURE
//  - Shared include cruise_defs.vh: command-index constants (CMD_BRAKE..CMD_COAST),
//    debouncer state encodings (IDLE/CHK_PRESS/PRESSED/CHK_REL), priority order.
//  - Sub-module stalk_debounce: synchroniser + debouncer FSM + press event, instanced
//    six times; top level holds auto-repeat timers and the priority arbiter.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8)
//  1 btn_set high 20 cycles -> single set pulse, 1 clock wide, after edge 6; none at release.
//  2 btn_accel pulse 2 cycles, 3 cycles low, 2 high -> no accel pulse (bounce rejected).
//  3 btn_cancel and btn_set rise same edge, held 10 -> cancel pulse only; set never pulses.
//  4 brake_sw held, then btn_resume pressed 10 -> brake pulse, brake_held=1, no resume.
//  5 AUTO_REPEAT_EN, btn_coast held 40 -> coast pulses at edges 6, 22, 30, 38; off: 6 only.
//  6 reset_n low mid CHK_PRESS of btn_accel -> outputs 0 at once; no pulse after release of reset
//    until a fresh full debounce completes.

Source files
------------

// File: rtl/cruise_stalk_ctrl_pkg.sv
// Shared definitions for the cruise-control stalk front end: command indices
// (index order is also arbitration priority), debouncer state encoding and
// the priority-pick helper used by the output arbiter.
package cruise_stalk_ctrl_pkg;

    localparam int NUM_CMDS = 6;

    // Lower index = higher priority.
    localparam int CMD_BRAKE  = 0;
    localparam int CMD_CANCEL = 1;
    localparam int CMD_SET    = 2;
    localparam int CMD_RESUME = 3;
    localparam int CMD_ACCEL  = 4;
    localparam int CMD_COAST  = 5;

    // Commands that a held brake pedal blocks; cancel and brake always pass.
    localparam logic [NUM_CMDS-1:0] BRAKE_BLOCKED = NUM_CMDS'(
        (1 << CMD_SET) | (1 << CMD_RESUME) | (1 << CMD_ACCEL) | (1 << CMD_COAST));

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_CHK_PRESS = 2'd1,
        DB_PRESSED   = 2'd2,
        DB_CHK_REL   = 2'd3
    } db_state_t;

    // One-hot grant of the highest-priority (lowest-index) request.
    function automatic logic [NUM_CMDS-1:0] pick_highest(input logic [NUM_CMDS-1:0] req);
        return req & ~(req - NUM_CMDS'(1));
    endfunction

endpackage

// File: rtl/cruise_stalk_ctrl_debounce.sv
// stalk_debounce: two-flop synchroniser plus debounce FSM for one switch.
// Emits a registered one-clock press event when a press is accepted, the
// debounced level (pressed until a release is confirmed) and a flag that is
// high only while the switch sits settled in the pressed state.
module stalk_debounce
    import cruise_stalk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press,
    output logic level,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt;

    // Bring the asynchronous switch into the clock domain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], raw};
    end

    assign s = sync_q[1];

    // State, counter and press-event registers.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= DB_IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // Debounce next-state logic; the counter only ever climbs to CNT_LAST.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            DB_IDLE: begin
                if (s) begin
                    state_nxt = DB_CHK_PRESS;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DB_CHK_PRESS: begin
                if (!s) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DB_PRESSED: begin
                if (!s) begin
                    state_nxt = DB_CHK_REL;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DB_CHK_REL: begin
                if (s) begin
                    state_nxt = DB_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level  = (state == DB_PRESSED) || (state == DB_CHK_REL);
    assign stable = (state == DB_PRESSED);

endmodule

// File: rtl/cruise_stalk_ctrl.sv
// cruise_stalk_ctrl: debounces the six stalk/brake inputs and issues at most
// one registered command pulse per clock in fixed priority
// brake > cancel > set > resume > accel > coast.
// Optional feature macro AUTO_REPEAT_EN: held accel/coast re-pulse after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module cruise_stalk_ctrl
    import cruise_stalk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 250000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_set,
    input  logic btn_accel,
    input  logic btn_coast,
    input  logic btn_cancel,
    input  logic btn_resume,
    input  logic brake_sw,
    output logic set,
    output logic accel,
    output logic coast,
    output logic cancel,
    output logic resume,
    output logic brake,
    output logic brake_held
);

    logic [NUM_CMDS-1:0] raw, press, level, stable;
    logic [NUM_CMDS-1:0] rep_evt, req, cmd_q;
    logic [1:0]          rep_hit;   // [0] accel, [1] coast
    logic                unused_bits;

    assign raw[CMD_BRAKE]  = brake_sw;
    assign raw[CMD_CANCEL] = btn_cancel;
    assign raw[CMD_SET]    = btn_set;
    assign raw[CMD_RESUME] = btn_resume;
    assign raw[CMD_ACCEL]  = btn_accel;
    assign raw[CMD_COAST]  = btn_coast;

    for (genvar i = 0; i < NUM_CMDS; i++) begin : g_db
        stalk_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (raw[i]),
            .press  (press[i]),
            .level  (level[i]),
            .stable (stable[i])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    for (genvar r = 0; r < 2; r++) begin : g_rep
        localparam int CH = (r == 0) ? CMD_ACCEL : CMD_COAST;
        logic [CNT_W-1:0] rep_cnt;
        logic             rep_phase;   // 0: waiting for first repeat, 1: periodic
        logic             hit;

        // Repeat timer: runs only while settled in PRESSED, restarts otherwise.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
                hit       <= 1'b0;
            end else if (!stable[CH]) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
                hit       <= 1'b0;
            end else if (rep_cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST)) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
                hit       <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
                hit     <= 1'b0;
            end
        end

        assign rep_hit[r] = hit;
    end
`else
    // Repeat timing is not built; keep the parameters referenced.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign rep_hit = '0;
`endif

    // Per-debouncer status bits that only some channels consume.
    assign unused_bits = ^{level, stable};

    // Request qualification: brake blocks driving commands, accel+coast cancel out.
    always_comb begin
        rep_evt            = '0;
        rep_evt[CMD_ACCEL] = rep_hit[0];
        rep_evt[CMD_COAST] = rep_hit[1];
        req = press | rep_evt;
        if (level[CMD_BRAKE]) req = req & ~BRAKE_BLOCKED;
        if (level[CMD_ACCEL] && level[CMD_COAST]) begin
            req[CMD_ACCEL] = 1'b0;
            req[CMD_COAST] = 1'b0;
        end
    end

    // Registered priority arbiter; losing requests are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cmd_q <= '0;
        else          cmd_q <= pick_highest(req);
    end

    assign brake      = cmd_q[CMD_BRAKE];
    assign cancel     = cmd_q[CMD_CANCEL];
    assign set        = cmd_q[CMD_SET];
    assign resume     = cmd_q[CMD_RESUME];
    assign accel      = cmd_q[CMD_ACCEL];
    assign coast      = cmd_q[CMD_COAST];
    assign brake_held = level[CMD_BRAKE];

endmodule

// File: tb/tb_cruise_stalk_ctrl.sv
// Self-checking bench for cruise_stalk_ctrl with short debounce/repeat times.
// Bit order of the 6-bit stimulus/response vectors used throughout:
// [0] brake, [1] cancel, [2] set, [3] resume, [4] accel, [5] coast
// (index order is also the priority order).
module tb_cruise_stalk_ctrl;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RP = 8;

    logic clock = 1'b0;
    logic reset_n;
    logic btn_set, btn_accel, btn_coast, btn_cancel, btn_resume, brake_sw;
    logic set, accel, coast, cancel, resume, brake, brake_held;

    int n_tests = 0;
    int n_fail  = 0;

    cruise_stalk_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_set   (btn_set),
        .btn_accel (btn_accel),
        .btn_coast (btn_coast),
        .btn_cancel(btn_cancel),
        .btn_resume(btn_resume),
        .brake_sw  (brake_sw),
        .set       (set),
        .accel     (accel),
        .coast     (coast),
        .cancel    (cancel),
        .resume    (resume),
        .brake     (brake),
        .brake_held(brake_held)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {coast, accel, resume, set, cancel, brake};
    endfunction

    task automatic set_raw(input logic [5:0] r);
        brake_sw   = r[0];
        btn_cancel = r[1];
        btn_set    = r[2];
        btn_resume = r[3];
        btn_accel  = r[4];
        btn_coast  = r[5];
    endtask

    // Leaves the bench just after a negedge with reset released; the next
    // posedge is "edge 0" for whatever is driven next.
    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        set_raw('0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Debounce rule: the level flips once the synchronised input has disagreed
    // with it for D consecutive samples. Repeats fire at press_time + RD + n*RP
    // while the press has been continuously settled.
    bit       m_r1[6], m_r2[6], m_lvl[6];
    int       m_run[6], m_since[6];
    int       m_cyc;
    bit [5:0] m_pending;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_r1[i] = 0; m_r2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_since[i] = 0;
        end
        m_cyc     = 0;
        m_pending = '0;
    endtask

    task automatic model_step(input logic [5:0] r);
        bit [5:0] evt, rep, req;
        bit       s, settled, found;
        int       e;
        m_cyc++;
        evt = '0;
        rep = '0;
        for (int i = 0; i < 6; i++) begin
            s       = m_r2[i];
            m_r2[i] = m_r1[i];
            m_r1[i] = r[i];
            settled = m_lvl[i] && (m_run[i] == 0);
`ifdef AUTO_REPEAT_EN
            if ((i == 4 || i == 5) && settled) begin
                e = m_cyc - m_since[i];
                if (e >= RD && ((e - RD) % RP) == 0) rep[i] = 1'b1;
            end
`endif
            if (s != m_lvl[i]) m_run[i]++;
            else               m_run[i] = 0;
            if (m_run[i] == D) begin
                m_lvl[i] = !m_lvl[i];
                m_run[i] = 0;
                evt[i]   = m_lvl[i];
            end
            if (m_lvl[i] && m_run[i] == 0 && !settled) m_since[i] = m_cyc;
        end
        e = 0;
        req = evt | rep;
        if (m_lvl[0]) begin
            req[2] = 0; req[3] = 0; req[4] = 0; req[5] = 0;
        end
        if (m_lvl[4] && m_lvl[5]) begin
            req[4] = 0; req[5] = 0;
        end
        m_pending = '0;
        found     = 0;
        for (int i = 0; i < 6; i++) begin
            if (req[i] && !found) begin
                m_pending[i] = 1'b1;
                found        = 1;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string    name;
        logic [5:0] raw;       // inputs raised together before edge 0
        int       hold;        // edges they stay high
        logic [5:0] exp_mask;  // outputs expected to pulse exactly once
        int       exp_edge;    // edge of that pulse (-1: none)
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    initial begin
        logic [5:0] r, o, got_mask;
        int         cnt[6];
        int         first, total;
        int         exp_q[$];
        int         got_q[$];
        logic [5:0] cur_raw;
        int         hold_left[6];
        bit         rst;
        logic [5:0] exp_now;
        bit         exp_held;

        reset_n = 1'b0;
        set_raw('0);

        vecs[0]  = '{"set_20",       6'b000100, 20, 6'b000100,  6};
        vecs[1]  = '{"cancel_set",   6'b000110, 10, 6'b000010,  6};
        vecs[2]  = '{"brake_only",   6'b000001, 10, 6'b000001,  6};
        vecs[3]  = '{"resume_only",  6'b001000, 10, 6'b001000,  6};
        vecs[4]  = '{"accel_only",   6'b010000, 10, 6'b010000,  6};
        vecs[5]  = '{"coast_only",   6'b100000, 10, 6'b100000,  6};
        vecs[6]  = '{"accel_coast",  6'b110000, 30, 6'b000000, -1};
        vecs[7]  = '{"brake_set",    6'b000101, 10, 6'b000001,  6};
        vecs[8]  = '{"brake_cancel", 6'b000011, 10, 6'b000001,  6};
        vecs[9]  = '{"set_3cyc",     6'b000100,  3, 6'b000000, -1};
        vecs[10] = '{"set_4cyc",     6'b000100,  4, 6'b000100,  6};
        vecs[11] = '{"resume_accel", 6'b011000, 10, 6'b001000,  6};

        // Reset state.
        apply_reset();
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_held", 32'(brake_held), 32'd0);

        // Table-driven single-press scenarios.
        for (int v = 0; v < NV; v++) begin
            apply_reset();
            set_raw(vecs[v].raw);
            for (int i = 0; i < 6; i++) cnt[i] = 0;
            first = -1;
            for (int e = 0; e < vecs[v].hold + 14; e++) begin
                @(posedge clock);
                #1;
                o = outs();
                if (o != '0 && first < 0) first = e;
                for (int i = 0; i < 6; i++) cnt[i] += int'(o[i]);
                if (e == 7 && vecs[v].hold > 8)
                    check({vecs[v].name, "_held"}, 32'(brake_held), 32'(vecs[v].raw[0]));
                if (e == vecs[v].hold - 1) set_raw('0);
            end
            got_mask = '0;
            total    = 0;
            for (int i = 0; i < 6; i++) begin
                got_mask[i] = (cnt[i] > 0);
                total += cnt[i];
            end
            check({vecs[v].name, "_mask"},  32'(got_mask), 32'(vecs[v].exp_mask));
            check({vecs[v].name, "_count"}, 32'(total),    32'($countones(vecs[v].exp_mask)));
            check({vecs[v].name, "_edge"},  32'(first),    32'(vecs[v].exp_edge));
        end

        // Bounce: accel high 2, low 3, high 2 -> rejected.
        apply_reset();
        set_raw(6'b010000);
        total = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock);
            #1;
            total += $countones(outs());
            set_raw(((e + 1) inside {1, 5, 6}) ? 6'b010000 : 6'b000000);
        end
        check("bounce_pulses", 32'(total), 32'd0);

        // Brake held, resume pressed meanwhile; then brake release timing.
        apply_reset();
        r = 6'b000001;
        set_raw(r);
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        for (int e = 0; e < 45; e++) begin
            @(posedge clock);
            #1;
            o = outs();
            for (int i = 0; i < 6; i++) cnt[i] += int'(o[i]);
            if (e == 20) check("brk_held_on", 32'(brake_held), 32'd1);
            if (e == 34) check("brk_held_last", 32'(brake_held), 32'd1);
            if (e == 35) check("brk_held_off", 32'(brake_held), 32'd0);
            if (e == 10) r[3] = 1'b1;
            if (e == 19) r[3] = 1'b0;
            if (e == 29) r[0] = 1'b0;
            set_raw(r);
        end
        check("brk_brake_cnt",  32'(cnt[0]), 32'd1);
        check("brk_resume_cnt", 32'(cnt[3]), 32'd0);

        // Coast held 40 edges: auto-repeat timing.
        apply_reset();
        set_raw(6'b100000);
        got_q.delete();
`ifdef AUTO_REPEAT_EN
        exp_q = '{6, 22, 30, 38};
`else
        exp_q = '{6};
`endif
        for (int e = 0; e < 60; e++) begin
            @(posedge clock);
            #1;
            if (coast) got_q.push_back(e);
            if (e == 39) set_raw('0);
        end
        check("rep_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rep_edge%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Reset in the middle of an accel debounce.
        apply_reset();
        set_raw(6'b010000);
        for (int e = 0; e < 4; e++) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        total = 0;
        first = -1;
        for (int e = 0; e < 14; e++) begin
            @(posedge clock);
            #1;
            if (accel && first < 0) first = e;
            total += $countones(outs());
        end
        check("midrst_edge",  32'(first), 32'd6);
        check("midrst_count", 32'(total), 32'd1);

        // Asynchronous reset clears a live pulse immediately.
        apply_reset();
        set_raw(6'b000100);
        for (int e = 0; e < 7; e++) begin
            @(posedge clock);
            #1;
        end
        check("async_pre", 32'(set), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clear", 32'(outs()), 32'd0);
        @(negedge clock);
        set_raw('0);
        reset_n = 1'b1;

        // Randomised stimulus against the reference model.
        apply_reset();
        model_reset();
        cur_raw = '0;
        for (int i = 0; i < 6; i++) hold_left[i] = $urandom_range(1, 10);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 6; i++) begin
                if (hold_left[i] == 0) begin
                    cur_raw[i]   = ~cur_raw[i];
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                                : $urandom_range(4, 30);
                end else begin
                    hold_left[i]--;
                end
            end
            reset_n = !rst;
            set_raw(cur_raw);
            @(posedge clock);
            #1;
            if (rst) begin
                model_reset();
                exp_now  = '0;
                exp_held = 0;
            end else begin
                exp_now = m_pending;
                model_step(cur_raw);
                exp_held = m_lvl[0];
            end
            check("rand_cmd",  32'(outs()),     32'(exp_now));
            check("rand_held", 32'(brake_held), 32'(exp_held));
        end
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
